// File: rtl/bldc_motor_ctrl_pkg.sv
// Shared definitions for the six-step BLDC driver: register map, CONTROL
// field positions, bus response codes, leg encoding and the commutation table.
package bldc_motor_ctrl_pkg;

   localparam logic [1:0] ADDR_PERIOD  = 2'd0;
   localparam logic [1:0] ADDR_COMPARE = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_DIR       = 1;
   localparam int CTRL_PHASE_LSB = 2;
   localparam int CTRL_W_PHASE   = 5;
   localparam int CTRL_DIV_LSB   = 6;
   localparam int CTRL_TOP_LSB   = 12;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int NUM_LEGS = 3;

   typedef enum logic [1:0] {
      LEG_U    = 2'd0,
      LEG_V    = 2'd1,
      LEG_W    = 2'd2,
      LEG_NONE = 2'd3
   } legT;

   // The leg not named here floats for that phase.
   typedef struct packed {
      logic valid;
      legT  pwmLeg;
      legT  lowLeg;
   } commuteT;

   typedef struct packed {
      logic [15:0] top;
      logic [5:0]  div;
      logic [2:0]  phase;
      logic        dir;
      logic        en;
   } ctrlRegT;

   function automatic commuteT commuteLookup(input logic [2:0] phase);
      commuteT c;
      c.valid  = (phase <= 3'd5);
      c.pwmLeg = LEG_NONE;
      c.lowLeg = LEG_NONE;
      case (phase)
         3'd0: begin c.pwmLeg = LEG_U; c.lowLeg = LEG_V; end
         3'd1: begin c.pwmLeg = LEG_U; c.lowLeg = LEG_W; end
         3'd2: begin c.pwmLeg = LEG_V; c.lowLeg = LEG_W; end
         3'd3: begin c.pwmLeg = LEG_V; c.lowLeg = LEG_U; end
         3'd4: begin c.pwmLeg = LEG_W; c.lowLeg = LEG_U; end
         3'd5: begin c.pwmLeg = LEG_W; c.lowLeg = LEG_V; end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] nextPhase(input logic [2:0] phase, input logic dir);
      if (dir) return (phase == 3'd0) ? 3'd5 : phase - 3'd1;
      else     return (phase == 3'd5) ? 3'd0 : phase + 3'd1;
   endfunction

endpackage

// File: rtl/bldcm_dead_time.sv
// Per-leg dead-time guard. Registers the requested high/low drive; a side may
// only turn on once the opposite side has been off for pDeadTime consecutive
// clocks. Turn-off passes straight through (one register stage).
//   iClock, iReset_n : clock, synchronous active-low reset
//   iReqH, iReqL     : requested logical high/low drive
//   oH, oL           : dead-time-safe logical drive, never both 1
module bldcm_dead_time #(
   parameter int pDeadTime = 5
) (
   input  logic iClock,
   input  logic iReset_n,
   input  logic iReqH,
   input  logic iReqL,
   output logic oH,
   output logic oL
);
   localparam int CW = $clog2(pDeadTime + 1);
   localparam logic [CW-1:0] DT = CW'(pDeadTime);

   // Consecutive clocks each output has been low, saturating at DT.
   logic [CW-1:0] hOffCnt, lOffCnt;
   logic          hNext, lNext;

   // High wins a simultaneous request so the pair can never both be driven.
   always_comb begin
      hNext = iReqH && (lOffCnt >= DT);
      lNext = iReqL && !iReqH && (hOffCnt >= DT);
   end

   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         oH      <= 1'b0;
         oL      <= 1'b0;
         hOffCnt <= '0;
         lOffCnt <= '0;
      end else begin
         oH      <= hNext;
         oL      <= lNext;
         hOffCnt <= hNext ? '0 : ((hOffCnt >= DT) ? DT : hOffCnt + CW'(1));
         lOffCnt <= lNext ? '0 : ((lOffCnt >= DT) ? DT : lOffCnt + CW'(1));
      end
   end

endmodule

// File: rtl/bldc_motor_ctrl.sv
// Six-step trapezoidal BLDC driver with an Avalon-MM slave.
//   iClock, iReset_n      : clock, synchronous active-low reset
//   iAddr/iRead/iWrite    : word address and strobes
//   iWdata, oRdata, oResp : write data, read data (1-cycle latency), response
//   oUh..oWl              : gate pins, each XORed with its pInvert parameter
// A step timer advances the commutation phase; a prescaled PWM with a
// wrap-shadowed compare modulates the active leg; each leg passes through a
// dead-time guard before reaching the pins.
module bldc_motor_ctrl
   import bldc_motor_ctrl_pkg::*;
#(
   parameter int pFreqClock             = 50000000,
   parameter int pPwmDeadTimeClockCycle = 5,
   parameter bit pInvertUh              = 1'b0,
   parameter bit pInvertUl              = 1'b0,
   parameter bit pInvertVh              = 1'b0,
   parameter bit pInvertVl              = 1'b0,
   parameter bit pInvertWh              = 1'b0,
   parameter bit pInvertWl              = 1'b0
) (
   input  logic        iClock,
   input  logic        iReset_n,
   input  logic [1:0]  iAddr,
   input  logic        iRead,
   output logic [31:0] oRdata,
   input  logic        iWrite,
   input  logic [31:0] iWdata,
   output logic [1:0]  oResp,
   output logic        oUh,
   output logic        oUl,
   output logic        oVh,
   output logic        oVl,
   output logic        oWh,
   output logic        oWl
);
   if (pFreqClock <= 0) begin : gBadFreq
      $error("pFreqClock must be positive");
   end
   if (pPwmDeadTimeClockCycle < 1) begin : gBadDeadTime
      $error("pPwmDeadTimeClockCycle must be at least 1");
   end

   ctrlRegT             ctrl;
   logic [31:0]         period, compare;
   logic [31:0]         stepCnt, stepCntNext;
   logic [2:0]          phaseNext;
   logic [5:0]          divCnt;
   logic [15:0]         pwmCnt, cmpShadow;
   logic                run, stepTc, tick, pwmWrap, pwm;
   logic                periodWr, ctrlWr, phaseLoad;
   logic [31:0]         rdMux;
   commuteT             cm;
   logic [NUM_LEGS-1:0] legH, legL;

   // ---------------- register writes and step sequencer ----------------
   assign periodWr  = iWrite && (iAddr == ADDR_PERIOD);
   assign ctrlWr    = iWrite && (iAddr == ADDR_CONTROL);
   assign phaseLoad = ctrlWr && iWdata[CTRL_W_PHASE];
   assign run       = ctrl.en && (period != '0);
   assign stepTc    = run && (stepCnt == period - 32'd1);

   // A PERIOD write beats a coincident terminal count; a PHASE load beats a
   // coincident advance. Invalid phases (6,7) never advance.
   always_comb begin
      stepCntNext = stepCnt;
      phaseNext   = ctrl.phase;
      if (!ctrl.en || periodWr || phaseLoad) stepCntNext = '0;
      else if (run)                          stepCntNext = stepTc ? '0 : stepCnt + 32'd1;
      if (phaseLoad)
         phaseNext = iWdata[CTRL_PHASE_LSB +: 3];
      else if (stepTc && !periodWr && (ctrl.phase <= 3'd5))
         phaseNext = nextPhase(ctrl.phase, ctrl.dir);
   end

   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         ctrl    <= '0;
         period  <= '0;
         compare <= '0;
         stepCnt <= '0;
      end else begin
         stepCnt    <= stepCntNext;
         ctrl.phase <= phaseNext;
         if (periodWr) period <= iWdata;
         if (iWrite && (iAddr == ADDR_COMPARE)) compare <= iWdata;
         if (ctrlWr) begin
            ctrl.top <= iWdata[CTRL_TOP_LSB +: 16];
            ctrl.div <= iWdata[CTRL_DIV_LSB +: 6];
            ctrl.dir <= iWdata[CTRL_DIR];
            ctrl.en  <= iWdata[CTRL_EN];
         end
      end
   end

   // ---------------- PWM ----------------
   // >= rather than == so a TOP/DIV lowered below the running count still wraps promptly.
   assign tick    = ctrl.en && (divCnt >= ctrl.div);
   assign pwmWrap = tick && (pwmCnt >= ctrl.top);
   assign pwm     = (pwmCnt < cmpShadow);

   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         divCnt    <= '0;
         pwmCnt    <= '0;
         cmpShadow <= '0;
      end else if (!ctrl.en) begin
         divCnt <= '0;
         pwmCnt <= '0;
      end else begin
         divCnt <= tick ? '0 : divCnt + 6'd1;
         if (pwmWrap) begin
            pwmCnt    <= '0;
            cmpShadow <= compare[15:0];
         end else if (tick) begin
            pwmCnt <= pwmCnt + 16'd1;
         end
      end
   end

   // ---------------- commutation and per-leg dead time ----------------
   assign cm = commuteLookup(ctrl.phase);

   for (genvar g = 0; g < NUM_LEGS; g++) begin : gLeg
      localparam logic [1:0] LEG = 2'(g);
      logic reqH, reqL;

      always_comb begin
         reqH = 1'b0;
         reqL = 1'b0;
         if (ctrl.en && cm.valid) begin
            if (cm.pwmLeg == LEG) begin
               reqH = pwm;
               reqL = !pwm;
            end else if (cm.lowLeg == LEG) begin
               reqL = 1'b1;
            end
         end
      end

      bldcm_dead_time #(.pDeadTime(pPwmDeadTimeClockCycle)) uDeadTime (
         .iClock  (iClock),
         .iReset_n(iReset_n),
         .iReqH   (reqH),
         .iReqL   (reqL),
         .oH      (legH[g]),
         .oL      (legL[g])
      );
   end

   assign oUh = legH[0] ^ pInvertUh;
   assign oUl = legL[0] ^ pInvertUl;
   assign oVh = legH[1] ^ pInvertVh;
   assign oVl = legL[1] ^ pInvertVl;
   assign oWh = legH[2] ^ pInvertWh;
   assign oWl = legL[2] ^ pInvertWl;

   // ---------------- bus read / response ----------------
   always_comb begin
      rdMux = '0;
      case (iAddr)
         ADDR_PERIOD:  rdMux = period;
         ADDR_COMPARE: rdMux = compare;
         ADDR_CONTROL: rdMux = {4'd0, ctrl.top, ctrl.div, 1'b0, ctrl.phase, ctrl.dir, ctrl.en};
         ADDR_STATUS:  rdMux = {27'd0, ctrl.phase, run, ctrl.en};
         default:      rdMux = '0;
      endcase
   end

   // Read data holds until the next read; writes only update the response.
   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         oRdata <= '0;
         oResp  <= RESP_OKAY;
      end else if (iRead) begin
         oRdata <= rdMux;
         oResp  <= RESP_OKAY;
      end else if (iWrite) begin
         oResp  <= (iAddr == ADDR_STATUS) ? RESP_SLVERR : RESP_OKAY;
      end
   end

endmodule

// File: tb/tb_bldc_motor_ctrl.sv
// Directed bench for bldc_motor_ctrl: low-side pins inverted, dead time 5.
module tb_bldc_motor_ctrl;
   logic        iClock, iReset_n, iRead, iWrite;
   logic [1:0]  iAddr, oResp;
   logic [31:0] iWdata, oRdata;
   logic        oUh, oUl, oVh, oVl, oWh, oWl;
   logic [5:0]  pins;
   int          nChecks = 0;
   int          nErrors = 0;
   logic [31:0] rd;
   logic [1:0]  rr;

   bldc_motor_ctrl #(
      .pFreqClock(50000000), .pPwmDeadTimeClockCycle(5),
      .pInvertUh(1'b0), .pInvertUl(1'b1), .pInvertVh(1'b0),
      .pInvertVl(1'b1), .pInvertWh(1'b0), .pInvertWl(1'b1)
   ) dut (
      .iClock(iClock), .iReset_n(iReset_n), .iAddr(iAddr), .iRead(iRead),
      .oRdata(oRdata), .iWrite(iWrite), .iWdata(iWdata), .oResp(oResp),
      .oUh(oUh), .oUl(oUl), .oVh(oVh), .oVl(oVl), .oWh(oWh), .oWl(oWl)
   );

   assign pins = {oUh, oUl, oVh, oVl, oWh, oWl};

   initial iClock = 1'b0;
   always #5 iClock = ~iClock;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", nErrors);
      $fatal(1, "watchdog");
   end

   // Both called at a negedge; the access edge is the next posedge.
   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      iAddr = a; iWdata = d; iWrite = 1'b1;
      @(negedge iClock);
      iWrite = 1'b0;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d, output logic [1:0] r);
      iAddr = a; iRead = 1'b1;
      @(negedge iClock);
      iRead = 1'b0;
      d = oRdata; r = oResp;
   endtask

   task automatic test_reset();
      // All logical drive 0: high pins 0, inverted low pins 1.
      nChecks++; if (pins !== 6'b010101) begin nErrors++; $display("FAIL reset_pins: got %b want 010101", pins); end
      nChecks++; if (oRdata !== 32'h0) begin nErrors++; $display("FAIL reset_rdata: got %h want 0", oRdata); end
      nChecks++; if (oResp !== 2'b00) begin nErrors++; $display("FAIL reset_resp: got %b want 00", oResp); end
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h0) begin nErrors++; $display("FAIL reset_status: got %h want 0", rd); end
      busRead(2'd2, rd, rr);
      nChecks++; if (rd !== 32'h0) begin nErrors++; $display("FAIL reset_control: got %h want 0", rd); end
   endtask

   task automatic test_phase_write();
      busWrite(2'd2, 32'h0FFFF00D);
      busRead(2'd2, rd, rr);
      nChecks++; if (rd !== 32'h0FFFF001) begin nErrors++; $display("FAIL phase_no_wphase: got %h want 0FFFF001", rd); end
      busWrite(2'd2, 32'h0FFFF02D);
      busRead(2'd2, rd, rr);
      nChecks++; if (rd !== 32'h0FFFF00D) begin nErrors++; $display("FAIL phase_wphase: got %h want 0FFFF00D", rd); end
      busWrite(2'd2, 32'h0);
   endtask

   // STATUS = phase<<2 | RUN<<1 | EN. After the restarting write, state k has
   // stepCnt=k; the phase moves at the edge ending state 3471 (and 6943).
   task automatic test_stepping();
      busWrite(2'd0, 32'd3472);
      busWrite(2'd2, 32'h31);          // load phase 4, DIR=0, EN=1
      repeat (3470) @(negedge iClock);
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h13) begin nErrors++; $display("FAIL step_fwd_before: got %h want 13", rd); end
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h13) begin nErrors++; $display("FAIL step_fwd_tc: got %h want 13", rd); end
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h17) begin nErrors++; $display("FAIL step_fwd_adv: got %h want 17", rd); end
      repeat (3470) @(negedge iClock);
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h17) begin nErrors++; $display("FAIL step_fwd_hold5: got %h want 17", rd); end
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h03) begin nErrors++; $display("FAIL step_fwd_wrap: got %h want 03", rd); end
      busWrite(2'd2, 32'h27);          // load phase 1, DIR=1, EN=1
      repeat (3471) @(negedge iClock);
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h07) begin nErrors++; $display("FAIL step_rev_tc: got %h want 07", rd); end
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h03) begin nErrors++; $display("FAIL step_rev_adv: got %h want 03", rd); end
      repeat (3470) @(negedge iClock);
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h03) begin nErrors++; $display("FAIL step_rev_hold0: got %h want 03", rd); end
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h17) begin nErrors++; $display("FAIL step_rev_wrap: got %h want 17", rd); end
   endtask

   task automatic test_coincident();
      busWrite(2'd2, 32'h29);          // load phase 2, DIR=0, EN=1
      repeat (3471) @(negedge iClock);
      busWrite(2'd0, 32'd3472);        // lands on the terminal-count edge
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h0B) begin nErrors++; $display("FAIL period_wr_wins: got %h want 0B", rd); end
      repeat (3470) @(negedge iClock);
      busWrite(2'd2, 32'h35);          // phase 5 load on the terminal-count edge
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h17) begin nErrors++; $display("FAIL phase_ld_wins: got %h want 17", rd); end
      busWrite(2'd0, 32'd0);
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h15) begin nErrors++; $display("FAIL run_off_period0: got %h want 15", rd); end
   endtask

   task automatic test_status_write();
      busWrite(2'd3, 32'hFFFFFFFF);
      nChecks++; if (oResp !== 2'b10) begin nErrors++; $display("FAIL status_wr_resp: got %b want 10", oResp); end
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h15 || rr !== 2'b00) begin nErrors++; $display("FAIL status_wr_state: got %h/%b want 15/00", rd, rr); end
      busRead(2'd2, rd, rr);
      nChecks++; if (rd !== 32'h15) begin nErrors++; $display("FAIL status_wr_ctrl: got %h want 15", rd); end
   endtask

   // Phase 0: U is the PWM leg, V low, W floating. TOP=15, DIV=3 gives a
   // 64-clock period; compare 12 -> 48 clocks of pwm, of which the first 5 are
   // eaten by dead time, so Uh is high 43. Compare 3 -> 12 - 5 = 7.
   task automatic test_pwm();
      logic h[200], l[200];
      logic prev, found;
      int   fall1, rise2, fall2, rise3, overlaps, vBad, wBad, minGap, nGaps, run0;
      busWrite(2'd2, 32'h20);          // phase 0, disabled: PWM counters cleared
      busWrite(2'd1, 32'd12);
      busRead(2'd1, rd, rr);
      nChecks++; if (rd !== 32'd12) begin nErrors++; $display("FAIL compare_rd: got %h want 0c", rd); end
      busWrite(2'd2, 32'h0000F0C1);
      prev = oUh; found = 1'b0;
      for (int t = 0; t < 300 && !found; t++) begin
         @(negedge iClock);
         if (oUh && !prev) found = 1'b1;
         prev = oUh;
      end
      nChecks++; if (!found) begin nErrors++; $display("FAIL pwm_first_rise: got none want rise within 300 clocks"); end
      vBad = 0; wBad = 0;
      for (int i = 0; i < 200; i++) begin
         h[i] = oUh; l[i] = !oUl;
         if (oVh !== 1'b0 || oVl !== 1'b0) vBad++;
         if (oWh !== 1'b0 || oWl !== 1'b1) wBad++;
         if (i == 10) begin iAddr = 2'd1; iWdata = 32'd3; iWrite = 1'b1; end
         if (i == 11) iWrite = 1'b0;
         @(negedge iClock);
      end
      fall1 = -1; rise2 = -1; fall2 = -1; rise3 = -1;
      for (int i = 1; i < 200; i++) begin
         if (fall1 < 0 && !h[i] && h[i-1]) fall1 = i;
         else if (fall1 >= 0 && rise2 < 0 && h[i] && !h[i-1]) rise2 = i;
         else if (rise2 >= 0 && fall2 < 0 && !h[i] && h[i-1]) fall2 = i;
         else if (fall2 >= 0 && rise3 < 0 && h[i] && !h[i-1]) rise3 = i;
      end
      nChecks++; if (fall1 != 43) begin nErrors++; $display("FAIL pwm_high_cmp12: got %0d want 43", fall1); end
      nChecks++; if (rise2 != 64) begin nErrors++; $display("FAIL pwm_period_a: got %0d want 64", rise2); end
      nChecks++; if (fall2 - rise2 != 7) begin nErrors++; $display("FAIL pwm_high_cmp3: got %0d want 7", fall2 - rise2); end
      nChecks++; if (rise3 - rise2 != 64) begin nErrors++; $display("FAIL pwm_period_b: got %0d want 64", rise3 - rise2); end
      overlaps = 0; minGap = 1000; nGaps = 0; run0 = -1;
      for (int i = 0; i < 200; i++) begin
         if (h[i] && l[i]) overlaps++;
         if (!h[i] && !l[i]) begin
            if (run0 >= 0) run0++;
         end else begin
            if (run0 > 0) begin nGaps++; if (run0 < minGap) minGap = run0; end
            run0 = 0;
         end
      end
      nChecks++; if (overlaps != 0) begin nErrors++; $display("FAIL dt_overlap: got %0d want 0", overlaps); end
      nChecks++; if (nGaps < 4 || minGap < 5) begin nErrors++; $display("FAIL dt_gap: got %0d gaps min %0d want >=4 gaps min>=5", nGaps, minGap); end
      nChecks++; if (vBad != 0) begin nErrors++; $display("FAIL v_low_leg: got %0d bad samples want 0", vBad); end
      nChecks++; if (wBad != 0) begin nErrors++; $display("FAIL w_floating: got %0d bad samples want 0", wBad); end
   endtask

   task automatic test_phase7();
      busWrite(2'd0, 32'd10);
      busWrite(2'd2, 32'h0000F0FD);    // load phase 7, EN=1, keep TOP/DIV
      repeat (40) @(negedge iClock);
      nChecks++; if (pins !== 6'b010101) begin nErrors++; $display("FAIL phase7_pins: got %b want 010101", pins); end
      busRead(2'd3, rd, rr);
      nChecks++; if (rd !== 32'h1F) begin nErrors++; $display("FAIL phase7_hold: got %h want 1F", rd); end
   endtask

   initial begin
      iReset_n = 1'b0; iRead = 1'b0; iWrite = 1'b0; iAddr = 2'd0; iWdata = 32'd0;
      repeat (3) @(negedge iClock);
      iReset_n = 1'b1;
      @(negedge iClock);
      test_reset();
      test_phase_write();
      test_stepping();
      test_coincident();
      test_status_write();
      test_pwm();
      test_phase7();
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end
endmodule
